// File: rtl/ram_burst_pkg.sv
// Shared constants and types for the RAM burst reader and its output FIFO.
package ram_burst_pkg;

    // Clocks from address driven to read data valid on the RAM port.
    localparam int RD_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO: dout shows the head whenever empty is low.
module stream_fifo
    import ram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [clog2(DEPTH):0]   count,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master for one RAM port: issues reads against a credit limit and
// streams the returned words through a skid FIFO on a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing reads while words remain and FIFO credit allows
// DRAIN | all reads issued, waiting for the last words to be consumed
module ram_burst_reader
    import ram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int CW = clog2(FIFO_DEPTH) + 1;

    state_e                  state;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic [LEN_WIDTH-1:0]    issue_left;
    logic [LEN_WIDTH-1:0]    out_left;
    logic [RD_LATENCY-1:0]   vpipe;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           inflight;
    logic [CW:0]             credit_used;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    issue;
    logic                    handshake;
    logic                    cancel;
    logic                    finish;

    assign ram_addr = addr_cnt;
    assign ram_wr   = 1'b0;
    assign ram_din  = '0;
    assign m_valid  = !fifo_empty;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(vpipe[i]);
        end
    end

    // Reserve a FIFO slot for every read still in the RAM pipeline so returning
    // data always has somewhere to land, whatever the consumer does.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight} + (CW + 1)'(1);

    assign issue     = (state == ISSUE) && !abort && (issue_left != '0)
                       && (credit_used <= (CW + 1)'(FIFO_DEPTH));
    assign handshake = m_valid && m_ready;
    assign cancel    = (state != IDLE) && abort;
    assign finish    = (state != IDLE) && !abort && handshake
                       && (out_left == LEN_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            issue_left <= '0;
            out_left   <= '0;
            vpipe      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done  <= 1'b0;
            vpipe <= {vpipe[RD_LATENCY-2:0], issue};
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr_cnt   <= base;
                            issue_left <= length;
                            out_left   <= length;
                            busy       <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE, DRAIN: begin
                    if (cancel) begin
                        vpipe <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (issue) begin
                            addr_cnt   <= addr_cnt + ADDR_WIDTH'(1);
                            issue_left <= issue_left - LEN_WIDTH'(1);
                        end
                        if (handshake) begin
                            out_left <= out_left - LEN_WIDTH'(1);
                        end
                        if (finish) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if ((state == ISSUE) && issue
                                     && (issue_left == LEN_WIDTH'(1))) begin
                            state <= DRAIN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vpipe[RD_LATENCY-1]),
        .pop   (handshake),
        .flush (cancel),
        .din   (ram_dout),
        .dout  (m_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    outstanding_check: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, fifo_count} + {1'b0, inflight}) <= (CW + 1)'(FIFO_DEPTH));

    landing_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(vpipe[RD_LATENCY-1] && fifo_full && !handshake && !cancel));

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader against a 2-cycle registered RAM model.
module tb_ram_burst_reader;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int LW = 10;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [LW-1:0] length = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;

    logic [DW-1:0] mem [1 << AW];
    logic [AW-1:0] addr_q = '0;
    logic [DW-1:0] dout_q = '0;

    logic [DW-1:0] exp_q [$];
    logic          exp_done = 1'b0;
    logic          burst_active = 1'b0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    int            ready_mode = 0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    ram_burst_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .length   (length),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_wr   (ram_wr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    always #5 clk = ~clk;

    // RAM port: address registered, data registered one clock later.
    always @(posedge clk) begin
        addr_q <= ram_addr;
        dout_q <= mem[addr_q];
    end
    assign ram_dout = dout_q;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: done pulse timing, stall stability and in-order data.
    always @(negedge clk) begin
        if (rst_n) begin
            check("done", 32'(done), 32'(exp_done));
            exp_done = 1'b0;
            if (hold_v && m_valid) check("stall_stable", 32'(m_data), 32'(hold_d));
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", m_data, $time);
                end else begin
                    check("data", 32'(m_data), 32'(exp_q.pop_front()));
                    if (exp_q.size() == 0 && burst_active) begin
                        exp_done = 1'b1;
                        burst_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
        @(posedge clk);
        #1;
        start  = 1'b1;
        base   = b;
        length = l;
        for (int i = 0; i < int'(l); i++) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            exp_q.push_back(mem[a]);
        end
        burst_active = (l != '0);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (l == '0) begin
            exp_done = 1'b1;
            check("busy_len0", 32'(busy), 32'h0);
        end else begin
            check("busy_after_start", 32'(busy), 32'h1);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        if (busy || exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: got busy=%0d left=%0d expected idle", name, busy, exp_q.size());
            exp_q.delete();
            burst_active = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] saved_addr;
        int            n;

        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) mem[16 + i] = 16'hA0A0 + DW'(i);

        #2 rst_n = 1'b0;
        #20;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_wr", 32'(ram_wr), 32'h0);
        check("rst_ram_din", 32'(ram_din), 32'h0);
        check("rst_m_valid", 32'(m_valid), 32'h0);
        check("rst_m_data", 32'(m_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic burst and first-word latency.
        ready_mode = 0;
        issue_start(9'h010, 10'd4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("latency_not_early", 32'(m_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stream_back_to_back", 32'(m_valid), 32'h1);
        end
        wait_idle("basic");

        // Address wrap at the top of the RAM.
        issue_start(9'h1FE, 10'd4);
        wait_idle("wrap");
        check("wrap_final_addr", 32'(ram_addr), 32'h002);

        // Backpressure 1-0-0-1.
        ready_mode = 1;
        issue_start(9'h0A3, 10'd16);
        wait_idle("backpressure");
        ready_mode = 0;

        // Zero-length request.
        saved_addr = ram_addr;
        issue_start(9'h055, 10'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("len0_m_valid", 32'(m_valid), 32'h0);
        end
        check("len0_ram_addr", 32'(ram_addr), 32'(saved_addr));
        check("len0_busy", 32'(busy), 32'h0);

        // Abort two cycles after the first word.
        issue_start(9'h120, 10'd8);
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!m_valid) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL abort_wait_valid: got m_valid=0 expected 1");
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b1;
        base  = 9'h000;
        length = 10'd3;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        exp_q.delete();
        burst_active = 1'b0;
        exp_done = 1'b1;
        check("abort_m_valid", 32'(m_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_late_data", 32'(m_valid), 32'h0);
        end
        check("abort_start_dropped", 32'(busy), 32'h0);
        issue_start(9'h130, 10'd6);
        wait_idle("after_abort");

        // Reset in the middle of a burst.
        issue_start(9'h1F0, 10'd8);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        burst_active = 1'b0;
        exp_done = 1'b0;
        hold_v = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_ram_addr", 32'(ram_addr), 32'h0);
        check("midrst_m_valid", 32'(m_valid), 32'h0);
        check("midrst_m_data", 32'(m_data), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_idle_busy", 32'(busy), 32'h0);
        issue_start(9'h1FC, 10'd8);
        wait_idle("after_reset");

        // Randomized bursts with random backpressure.
        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            issue_start(AW'($urandom), LW'($urandom_range(1, 24)));
            wait_idle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
